wb_byte_master: RTL and testbench
=================================

Name: wb_byte_master

Overview:
- Wishbone initiator that turns single-byte commands from a debug/BIOS-sequencer port into 16-bit Wishbone classic cycles on the peripheral bus.
- Main use: driving byte-only slaves such as the POST code register and GPIO blocks from a non-CPU agent, such as a self-test sequencer or a UART debug bridge.
- Performs one transfer at a time, with an ack timeout.

Parameters:
- TIMEOUT, 255: number of cycles wb_stb_o may stay high without wb_ack_i before the cycle is aborted. Legal range 1..65535.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_ni  in  1  synchronous reset, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a clock edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  20  byte address
- cmd_dat  in  8  write data byte
- rsp_valid  out  1  one-cycle response strobe
- rsp_dat  out  8  read data; 0 for writes and errors
- rsp_err  out  1  set on timeout
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_adr_o  out  19  word address, [19:1]
- wb_we_o  out  1  write enable
- wb_sel_o  out  2  byte lane select
- wb_dat_o  out  16  write data
- wb_dat_i  in  16  read data
- wb_ack_i  in  1  acknowledge

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- While wb_rst_ni = 0, at the clock edge:
  - state = IDLE.
  - cyc/stb/we = 0; adr/sel/dat_o = 0.
  - rsp_valid/rsp_err = 0; rsp_dat = 0.
  - cmd_ready = 0 during reset.
- FSM states:
  - IDLE: cmd_ready = 1. On accept, register the command outputs and go to BUS.
  - BUS: cyc = stb = 1; all outputs held stable.
    - On wb_ack_i = 1: capture the selected lane of wb_dat_i into rsp_dat if read (0 if write), rsp_err = 0, drop cyc/stb/we/sel/adr/dat_o to 0 at the same edge, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, cyc/stb = 0, cmd_ready = 0. Go to IDLE.
- Lane mapping:
  - cmd_adr[0] = 0 → sel = 01, byte on dat_o[7:0], read from wb_dat_i[7:0].
  - cmd_adr[0] = 1 → sel = 10, byte on dat_o[15:8], read from wb_dat_i[15:8].
  - Write data is replicated on both lanes.
  - wb_adr_o = cmd_adr[19:1].
- Latency:
  - Command accepted at edge 0; stb high from cycle 1.
  - A slave acking one cycle after stb gives rsp_valid in cycle 3.
  - Best case, with ack in cycle 1: rsp_valid in cycle 2.
- Stb gap: stb is low for at least 2 cycles between consecutive transfers (RESP + IDLE). This guarantees a fresh stb rising edge for edge-detecting slaves.
- Responses:
  - rsp_valid is a pulse with no backpressure.
  - rsp_dat/rsp_err hold their value until the next response.
- wb_ack_i outside BUS is ignored.
- cmd_* is sampled only at the accept edge; later changes have no effect.
- Reset mid-BUS: cyc/stb drop at that edge, no response is issued, FSM returns to IDLE.

Optional Feature:
- Macro: WB_BYTE_MASTER_TIMEOUT_EN.
- When defined:
  - A 16-bit wait counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT - 1 and ack is still 0, the cycle aborts: drop cyc/stb, rsp_dat = 0, rsp_err = 1, go to RESP.
  - If ack and the timeout coincide, ack wins and rsp_err = 0.
- When not defined:
  - No counter is built; BUS waits for ack indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Write byte: cmd_we = 1, adr = 0x00080, dat = 0x3C; slave acks 1 cycle after stb → wb_adr_o = 0x00040, sel = 01, dat_o = 0x3C3C, we = 1. rsp_valid in cycle 3 with err = 0, rsp_dat = 0.
- Read high lane: adr = 0x00081, slave returns wb_dat_i = 0xA55A → sel = 10, rsp_dat = 0xA5. Same command with adr = 0x00080 → rsp_dat = 0x5A.
- Back-to-back: cmd_valid held high with 2 writes → stb is low for ≥ 2 cycles between cycles; both responses have err = 0; cmd_ready = 0 throughout BUS/RESP.
- Timeout (macro on, TIMEOUT = 4): no ack → stb high for exactly 4 cycles, then rsp_valid with err = 1, rsp_dat = 0. Ack in the 4th stb cycle → err = 0.
- Reset mid-cycle: assert wb_rst_ni = 0 during BUS → next edge has cyc = stb = 0 and no rsp_valid. After release, cmd_ready = 1 in the first cycle.
- Stray ack: pulse wb_ack_i during IDLE → no rsp_valid and no state change.

Source files
------------

// File: rtl/wb_byte_master.sv
// Wishbone classic initiator: one byte command in, one 16-bit bus cycle out, one response pulse back.
// Optional ack timeout enabled by defining WB_BYTE_MASTER_TIMEOUT_EN.
module wb_byte_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [19:0] cmd_adr,
    input  logic [7:0]  cmd_dat,
    output logic        rsp_valid,
    output logic [7:0]  rsp_dat,
    output logic        rsp_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [18:0] wb_adr_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_byte_master: TIMEOUT out of range 1..65535");
    end

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_dat;
    logic        r_cyc;
    logic        r_stb;
    logic [18:0] r_adr;
    logic        r_we;
    logic [1:0]  r_sel;
    logic [15:0] r_dat_o;

    logic        w_accept;
    logic        w_timeout;
    logic [7:0]  w_rd_byte;

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_wait;
    logic        r_rsp_err;
    assign w_timeout = (r_wait == TO_LAST) && !wb_ack_i;
    assign rsp_err   = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // cmd_ready is only ever high in IDLE, so it doubles as the accept qualifier
    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_rd_byte = r_sel[1] ? wb_dat_i[15:8] : wb_dat_i[7:0];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 8'h00;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_adr       <= 19'h0;
            r_we        <= 1'b0;
            r_sel       <= 2'b00;
            r_dat_o     <= 16'h0;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
            r_wait      <= 16'h0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_we        <= cmd_we;
                        r_adr       <= cmd_adr[19:1];
                        r_sel       <= cmd_adr[0] ? 2'b10 : 2'b01;
                        r_dat_o     <= {cmd_dat, cmd_dat};
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
                        r_wait      <= 16'h0;
`endif
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (wb_ack_i || w_timeout) begin
                        // ack has priority over a coincident timeout
                        r_rsp_dat   <= (wb_ack_i && !r_we) ? w_rd_byte : 8'h00;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
                        r_rsp_err   <= !wb_ack_i;
`endif
                        r_rsp_valid <= 1'b1;
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_we        <= 1'b0;
                        r_sel       <= 2'b00;
                        r_adr       <= 19'h0;
                        r_dat_o     <= 16'h0;
                        r_state     <= S_RESP;
                    end else begin
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
                        r_wait      <= r_wait + 16'd1;
`endif
                    end
                end
                S_RESP: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_adr_o  = r_adr;
    assign wb_we_o   = r_we;
    assign wb_sel_o  = r_sel;
    assign wb_dat_o  = r_dat_o;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: reset, write, read lanes, back-to-back, timeout, reset mid-cycle, stray ack.
module tb_wb_byte_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [19:0] cmd_adr;
    logic [7:0]  cmd_dat;
    logic        rsp_valid;
    logic [7:0]  rsp_dat;
    logic        rsp_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [18:0] wb_adr_o;
    logic        wb_we_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    int n_cmp = 0;
    int n_bad = 0;

    wb_byte_master #(.TIMEOUT(4)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .rsp_valid(rsp_valid),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_adr_o (wb_adr_o),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 20'h00001;
        cmd_dat   = 8'hFF;
        wb_dat_i  = 16'hFFFF;
        wb_ack_i  = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got cyc/stb/we/sel=%b required 00000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
        end
        n_cmp++;
        if ({wb_adr_o, wb_dat_o} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got adr=%h dat=%h required 0", wb_adr_o, wb_dat_o);
        end
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_dat} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_rsp: got ready=%b vld=%b err=%b dat=%h required 0", cmd_ready, rsp_valid, rsp_err, rsp_dat);
        end
        cmd_valid = 1'b0;
        wb_rst_ni = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 20'h00080;
        cmd_dat   = 8'h3C;
        tick();
        cmd_valid = 1'b0;
        cmd_dat   = 8'hFF;
        cmd_adr   = 20'hFFFFF;
        n_cmp++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, cmd_ready} !== 6'b111010) begin
            n_bad++;
            $display("FAIL write_ctl: got cyc/stb/we/sel/ready=%b required 111010", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, cmd_ready});
        end
        n_cmp++;
        if (wb_adr_o !== 19'h00040 || wb_dat_o !== 16'h3C3C) begin
            n_bad++;
            $display("FAIL write_bus: got adr=%h dat=%h required 00040 3c3c", wb_adr_o, wb_dat_o);
        end
        tick();
        wb_ack_i = 1'b1;
        n_cmp++;
        if (wb_stb_o !== 1'b1 || rsp_valid !== 1'b0 || wb_dat_o !== 16'h3C3C) begin
            n_bad++;
            $display("FAIL write_hold: got stb=%b vld=%b dat=%h required 1 0 3c3c", wb_stb_o, rsp_valid, wb_dat_o);
        end
        tick();
        wb_ack_i = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_dat} !== 10'b10_0000_0000) begin
            n_bad++;
            $display("FAIL write_rsp: got vld=%b err=%b dat=%h required 1 0 00", rsp_valid, rsp_err, rsp_dat);
        end
        n_cmp++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, cmd_ready} !== 6'b0) begin
            n_bad++;
            $display("FAIL write_drop: got cyc/stb/we/sel/ready=%b required 000000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, cmd_ready});
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL write_idle: got vld=%b ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic read_one(input logic [19:0] adr, input logic [1:0] exp_sel, input logic [7:0] exp_byte);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = adr;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (wb_sel_o !== exp_sel || wb_we_o !== 1'b0 || wb_adr_o !== adr[19:1]) begin
            n_bad++;
            $display("FAIL read_sel adr=%h: got sel=%b we=%b wadr=%h required %b 0 %h", adr, wb_sel_o, wb_we_o, wb_adr_o, exp_sel, adr[19:1]);
        end
        wb_dat_i = 16'hA55A;
        wb_ack_i = 1'b1;
        tick();
        wb_dat_i = 16'h0000;
        wb_ack_i = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_dat !== exp_byte || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL read_rsp adr=%h: got vld=%b dat=%h err=%b required 1 %h 0", adr, rsp_valid, rsp_dat, rsp_err, exp_byte);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_dat !== exp_byte || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL read_hold adr=%h: got vld=%b dat=%h ready=%b required 0 %h 1", adr, rsp_valid, rsp_dat, cmd_ready, exp_byte);
        end
    endtask

    task automatic test_read();
        read_one(20'h00081, 2'b10, 8'hA5);
        read_one(20'h00080, 2'b01, 8'h5A);
    endtask

    task automatic test_back_to_back();
        int  rises = 0;
        int  low = 100;
        int  gap = -1;
        int  nrsp = 0;
        int  errs = 0;
        int  ready_bad = 0;
        int  acc = 0;
        logic prev_stb = 1'b0;
        logic fire;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 20'h00010;
        cmd_dat   = 8'h11;
        for (int i = 0; i < 12; i++) begin
            if (wb_stb_o) begin
                if (!prev_stb) begin
                    rises++;
                    gap = low;
                    n_cmp++;
                    if (wb_dat_o !== ((rises == 1) ? 16'h1111 : 16'h2222)) begin
                        n_bad++;
                        $display("FAIL b2b_data%0d: got %h", rises, wb_dat_o);
                    end
                end
                low = 0;
                if (cmd_ready) ready_bad++;
            end else begin
                low++;
            end
            if (rsp_valid) begin
                nrsp++;
                if (rsp_err) errs++;
                if (cmd_ready) ready_bad++;
            end
            prev_stb = wb_stb_o;
            wb_ack_i = wb_stb_o;
            fire = cmd_ready && cmd_valid;
            tick();
            if (fire) begin
                acc++;
                cmd_adr = 20'h00011;
                cmd_dat = 8'h22;
                if (acc == 2) cmd_valid = 1'b0;
            end
        end
        wb_ack_i  = 1'b0;
        cmd_valid = 1'b0;
        n_cmp++;
        if (rises !== 2 || nrsp !== 2) begin
            n_bad++;
            $display("FAIL b2b_count: got stb_rises=%0d rsps=%0d required 2 2", rises, nrsp);
        end
        n_cmp++;
        if (gap < 2) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d low cycles required >=2", gap);
        end
        n_cmp++;
        if (errs !== 0 || ready_bad !== 0) begin
            n_bad++;
            $display("FAIL b2b_flags: got errs=%0d ready_in_bus=%0d required 0 0", errs, ready_bad);
        end
    endtask

    task automatic test_timeout();
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
        int   stb_cnt = 0;
        logic got = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 20'h00100;
        cmd_dat   = 8'h77;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!got) begin
                if (rsp_valid) got = 1'b1;
                else begin
                    if (wb_stb_o) stb_cnt++;
                    tick();
                end
            end
        end
        n_cmp++;
        if (got !== 1'b1 || stb_cnt !== 4) begin
            n_bad++;
            $display("FAIL timeout_len: got rsp=%b stb_cycles=%0d required 1 4", got, stb_cnt);
        end
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_dat !== 8'h00 || wb_stb_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_rsp: got err=%b dat=%h stb=%b required 1 00 0", rsp_err, rsp_dat, wb_stb_o);
        end
        tick();
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 20'h00081;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 16'hA55A;
            end
            tick();
        end
        wb_ack_i = 1'b0;
        wb_dat_i = 16'h0000;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 8'hA5) begin
            n_bad++;
            $display("FAIL timeout_ackwins: got vld=%b err=%b dat=%h required 1 0 a5", rsp_valid, rsp_err, rsp_dat);
        end
        tick();
`else
        int seen = 0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 20'h00100;
        cmd_dat   = 8'h77;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0 || wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1) begin
            n_bad++;
            $display("FAIL nowait_hold: got rsps=%0d stb=%b cyc=%b required 0 1 1", seen, wb_stb_o, wb_cyc_o);
        end
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL nowait_rsp: got vld=%b err=%b required 1 0", rsp_valid, rsp_err);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 20'h00200;
        cmd_dat   = 8'h99;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (wb_stb_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_stb: got %b required 1", wb_stb_o);
        end
        wb_rst_ni = 1'b0;
        tick();
        n_cmp++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_drop: got cyc=%b stb=%b vld=%b required 0 0 0", wb_cyc_o, wb_stb_o, rsp_valid);
        end
        wb_rst_ni = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_release: got ready=%b vld=%b required 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_stray_ack();
        wb_ack_i = 1'b1;
        wb_dat_i = 16'hBEEF;
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || wb_stb_o !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_ack1: got vld=%b stb=%b ready=%b required 0 0 1", rsp_valid, wb_stb_o, cmd_ready);
        end
        wb_ack_i = 1'b0;
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_ack2: got vld=%b ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
